perceptron_feeder: RTL and testbench

Upstream stage of the perceptron datapath. Assembles a serial stream of 8-bit samples into 4-lane input vectors, holds the weight/bias/threshold configuration, and presents a complete, stable operand set to the combinational perceptron with a valid/ready handshake. The downstream capture register consumes the perceptron result when it accepts the vector.

---
 rtl/perceptron_feeder.sv | 164 ++++++++++++++++
 tb/tb_perceptron_feeder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_feeder.sv
// perceptron_feeder: assembles a serial 8-bit sample stream into a 4-lane
// operand vector, holds staged and active weight/bias/threshold configuration,
// and presents the complete operand set downstream with a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready       sample stream handshake; s_data sample, s_last ends a short vector
//   cfg_we/addr/wdata     staging config write (0-3 weights, 4 bias, 5 threshold)
//   in0..in3              vector lanes
//   weight0..3/bias/threshold  active configuration
//   vec_valid/vec_ready   operand set handshake
//   vec_count             completed handshakes, wraps modulo 2^CNT_W
module perceptron_feeder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] in3,
  output logic [DATA_W-1:0] weight0,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] threshold,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [CNT_W-1:0]  vec_count
);

  localparam int unsigned LANES = 4;

  typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                         r_state, w_state_nxt;
  logic [1:0]                     r_idx, w_idx_nxt;
  logic [LANES-1:0][DATA_W-1:0]   r_lane, w_lane_nxt;
  logic [LANES-1:0][DATA_W-1:0]   r_stg_w, r_act_w;
  logic [DATA_W-1:0]              r_stg_bias, r_stg_thr;
  logic [DATA_W-1:0]              r_act_bias, r_act_thr;
  logic [CNT_W-1:0]               r_cnt, w_cnt_nxt;
  logic                           r_s_ready, w_s_ready_nxt;
  logic                           r_vec_valid, w_vec_valid_nxt;
  logic                           w_launch;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  // Next-state, lane assembly and handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_lane_nxt      = r_lane;
    w_cnt_nxt       = r_cnt;
    w_s_ready_nxt   = r_s_ready;
    w_vec_valid_nxt = r_vec_valid;
    w_launch        = 1'b0;
    case (r_state)
      ST_FILL: begin
        // s_ready is high for the whole of FILL, so s_valid alone accepts
        if (s_valid) begin
          w_lane_nxt[r_idx] = s_data;
          if (r_idx == 2'd3 || s_last) begin
            w_launch = 1'b1;
            // zero-pad lanes above the last sample of a short vector
            for (int unsigned i = 0; i < LANES; i++) begin
              if (2'(i) > r_idx) w_lane_nxt[2'(i)] = '0;
            end
            w_idx_nxt       = 2'd0;
            w_state_nxt     = ST_HOLD;
            w_s_ready_nxt   = 1'b0;
            w_vec_valid_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      ST_HOLD: begin
        if (vec_ready) begin
          w_cnt_nxt       = r_cnt + CNT_W'(1);
          w_state_nxt     = ST_FILL;
          w_s_ready_nxt   = 1'b1;
          w_vec_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= 2'd0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_s_ready   <= 1'b1;
      r_vec_valid <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_lane      <= w_lane_nxt;
      r_cnt       <= w_cnt_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_vec_valid <= w_vec_valid_nxt;
    end
  end

  // Staging configuration, writable in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_w    <= '0;
      r_stg_bias <= '0;
      r_stg_thr  <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0, 3'd1, 3'd2, 3'd3: r_stg_w[cfg_addr[1:0]] <= cfg_wdata;
        3'd4:                   r_stg_bias <= cfg_wdata;
        3'd5:                   r_stg_thr  <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Active configuration copies the pre-edge staging values at launch,
  // so a write on the launch edge waits for the next vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_w    <= '0;
      r_act_bias <= '0;
      r_act_thr  <= '0;
    end else if (w_launch) begin
      r_act_w    <= r_stg_w;
      r_act_bias <= r_stg_bias;
      r_act_thr  <= r_stg_thr;
    end
  end

  assign s_ready   = r_s_ready;
  assign vec_valid = r_vec_valid;
  assign vec_count = r_cnt;
  assign in0       = r_lane[0];
  assign in1       = r_lane[1];
  assign in2       = r_lane[2];
  assign in3       = r_lane[3];
  assign weight0   = r_act_w[0];
  assign weight1   = r_act_w[1];
  assign weight2   = r_act_w[2];
  assign weight3   = r_act_w[3];
  assign bias      = r_act_bias;
  assign threshold = r_act_thr;

endmodule

// File: tb/tb_perceptron_feeder.sv
// Directed testbench for perceptron_feeder: a 16-bit-counter instance plus a
// 2-bit-counter instance driven by the same stimulus for the wrap test.
module tb_perceptron_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_last, cfg_we, vec_ready;
  logic [7:0] s_data, cfg_wdata;
  logic [2:0] cfg_addr;

  logic       s_ready, vec_valid;
  logic [7:0] in0, in1, in2, in3, weight0, weight1, weight2, weight3, bias, threshold;
  logic [15:0] vec_count;

  logic       s_ready_b, vec_valid_b;
  logic [7:0] in0_b, in1_b, in2_b, in3_b, w0_b, w1_b, w2_b, w3_b, bias_b, thr_b;
  logic [1:0] vec_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perceptron_feeder #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .bias(bias), .threshold(threshold),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_count(vec_count)
  );

  perceptron_feeder #(.DATA_W(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data), .s_last(s_last),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in0(in0_b), .in1(in1_b), .in2(in2_b), .in3(in3_b),
    .weight0(w0_b), .weight1(w1_b), .weight2(w2_b), .weight3(w3_b),
    .bias(bias_b), .threshold(thr_b),
    .vec_valid(vec_valid_b), .vec_ready(vec_ready), .vec_count(vec_count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic chk_lanes(input string tag, input logic [7:0] a, b, c, d);
    chk({tag, ".in0"}, 32'(in0), 32'(a));
    chk({tag, ".in1"}, 32'(in1), 32'(b));
    chk({tag, ".in2"}, 32'(in2), 32'(c));
    chk({tag, ".in3"}, 32'(in3), 32'(d));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_wrap [5];
    exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; vec_ready = 1'b1;
    #12;
    // reset state
    chk("rst.s_ready", 32'(s_ready), 1);
    chk("rst.vec_valid", 32'(vec_valid), 0);
    chk_lanes("rst", 0, 0, 0, 0);
    chk("rst.weight0", 32'(weight0), 0);
    chk("rst.threshold", 32'(threshold), 0);
    chk("rst.vec_count", 32'(vec_count), 0);
    rst_n = 1'b1;

    // full vector
    cfg_write(3'd0, 8'd1); cfg_write(3'd1, 8'd2); cfg_write(3'd2, 8'd3);
    cfg_write(3'd3, 8'd4); cfg_write(3'd4, 8'd5); cfg_write(3'd5, 8'd10);
    cfg_write(3'd6, 8'hEE); cfg_write(3'd7, 8'hEE);
    send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0);
    chk("full.pre_valid", 32'(vec_valid), 0);
    chk("full.pre_ready", 32'(s_ready), 1);
    send(8'd40, 1'b0);
    chk("full.vec_valid", 32'(vec_valid), 1);
    chk("full.s_ready", 32'(s_ready), 0);
    chk_lanes("full", 10, 20, 30, 40);
    chk("full.weight0", 32'(weight0), 1);
    chk("full.weight1", 32'(weight1), 2);
    chk("full.weight2", 32'(weight2), 3);
    chk("full.weight3", 32'(weight3), 4);
    chk("full.bias", 32'(bias), 5);
    chk("full.threshold", 32'(threshold), 10);
    chk("full.count_hold", 32'(vec_count), 0);
    tick();
    chk("full.valid_drop", 32'(vec_valid), 0);
    chk("full.ready_rise", 32'(s_ready), 1);
    chk("full.vec_count", 32'(vec_count), 1);

    // short vector with zero padding, then a fresh fill from lane 0
    send(8'd7, 1'b1);
    chk("short.vec_valid", 32'(vec_valid), 1);
    chk_lanes("short", 7, 0, 0, 0);
    tick();
    chk("short.vec_count", 32'(vec_count), 2);
    send(8'd1, 1'b0);
    chk("short.next_in0", 32'(in0), 1);
    chk("short.next_in1", 32'(in1), 0);
    send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    chk("short.next_valid", 32'(vec_valid), 1);
    chk_lanes("short.next", 1, 2, 3, 4);
    tick();
    chk("short.next_count", 32'(vec_count), 3);

    // backpressure with sample traffic and a weight0 write during HOLD
    vec_ready = 1'b0;
    send(8'd11, 1'b0); send(8'd12, 1'b0); send(8'd13, 1'b0); send(8'd14, 1'b0);
    s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
    cfg_write(3'd0, 8'd99);
    for (int k = 0; k < 5; k++) tick();
    chk("bp.s_ready", 32'(s_ready), 0);
    chk("bp.vec_valid", 32'(vec_valid), 1);
    chk_lanes("bp", 11, 12, 13, 14);
    chk("bp.weight0", 32'(weight0), 1);
    chk("bp.vec_count", 32'(vec_count), 3);
    s_valid = 1'b0; s_last = 1'b0; vec_ready = 1'b1;
    tick();
    chk("bp.count_after", 32'(vec_count), 4);
    chk("bp.valid_after", 32'(vec_valid), 0);
    send(8'd21, 1'b0); send(8'd22, 1'b0); send(8'd23, 1'b0); send(8'd24, 1'b0);
    chk("bp.next_weight0", 32'(weight0), 99);
    chk_lanes("bp.next", 21, 22, 23, 24);
    tick();
    chk("bp.next_count", 32'(vec_count), 5);

    // configuration write on the launch edge stays staged
    send(8'd31, 1'b0); send(8'd32, 1'b0); send(8'd33, 1'b0);
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_wdata = 8'd77;
    send(8'd34, 1'b0);
    cfg_we = 1'b0;
    chk("samecfg.old_bias", 32'(bias), 5);
    tick();
    chk("samecfg.count", 32'(vec_count), 6);
    send(8'd41, 1'b0); send(8'd42, 1'b0); send(8'd43, 1'b0); send(8'd44, 1'b0);
    chk("samecfg.new_bias", 32'(bias), 77);
    tick();
    chk("samecfg.count2", 32'(vec_count), 7);

    // asynchronous reset in the middle of a fill
    send(8'd51, 1'b0); send(8'd52, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.s_ready", 32'(s_ready), 1);
    chk("rstmid.vec_valid", 32'(vec_valid), 0);
    chk_lanes("rstmid", 0, 0, 0, 0);
    chk("rstmid.weight0", 32'(weight0), 0);
    chk("rstmid.bias", 32'(bias), 0);
    chk("rstmid.vec_count", 32'(vec_count), 0);
    #1 rst_n = 1'b1;
    send(8'd61, 1'b0); send(8'd62, 1'b0); send(8'd63, 1'b0); send(8'd64, 1'b0);
    chk("rstmid.vec_valid_new", 32'(vec_valid), 1);
    chk_lanes("rstmid.new", 61, 62, 63, 64);
    tick();
    chk("rstmid.count_new", 32'(vec_count), 1);

    // counter wrap on the 2-bit instance after a clean reset
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(8'(k + 1), 1'b1);
      tick();
      chk($sformatf("wrap.count2[%0d]", k), 32'(vec_count_b), 32'(exp_wrap[k]));
      chk($sformatf("wrap.count16[%0d]", k), 32'(vec_count), 32'(k + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
